// File: rtl/ahb_sram_slv.sv
// AHB-Lite SRAM slave: 2^ADDR_W x 32-bit word memory with programmable
// wait states, byte/halfword/word writes and a two-cycle ERROR response
// for misaligned or oversized transfers.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no data phase in flight; zero-wait OKAY; may accept address
// WAIT   | OKAY data phase stalled; down-counter runs to terminal 0
// LAST   | OKAY data phase completes; write lands / read data driven
// ERR1   | first ERROR cycle (hready low)
// ERR2   | second ERROR cycle (hready high); may accept next address
module ahb_sram_slv #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int AB    = ADDR_W + 2;
  // Counter reload; with zero wait states WAIT is never entered.
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AB-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;

  logic [31:0]     mem [DEPTH];

  logic            can_accept;
  logic            accept;
  logic            req_err;
  logic [3:0]      byte_en;
  logic [ADDR_W-1:0] word_idx;

  // hburst/hprot and address bits above the memory window have no effect.
  logic            unused_inputs;
  assign unused_inputs = ^{hburst, hprot, haddr[31:AB]};

  assign word_idx = addr_q[AB-1:2];

  // Address-phase acceptance and alignment/size error classification.
  always_comb begin
    can_accept = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
    accept     = hsel && htrans[1] && can_accept;
    req_err    = (hsize > 3'b010)
              || ((hsize == 3'b001) && haddr[0])
              || ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  end

  // Next-state, wait down-counter and data-phase control capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    if (accept) begin
      addr_d  = haddr[AB-1:0];
      size_d  = hsize;
      write_d = hwrite;
    end
    case (state_q)
      S_IDLE, S_LAST, S_ERR2: begin
        if (accept) begin
          if (req_err) begin
            state_d = S_ERR1;
          end else if (WAIT_CYC > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_LAST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_LAST;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Little-endian byte lanes from the registered size and low address bits.
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'b000:  byte_en = 4'b0001 << addr_q[1:0];
      3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Memory write on the LAST edge; a reset in that cycle suppresses it.
  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst && (state_q == S_LAST) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  // Bus response; reset forces the idle OKAY response immediately.
  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = 32'h0;
    if (!pad_cpu_rst) begin
      hready = can_accept;
      if ((state_q == S_ERR1) || (state_q == S_ERR2)) begin
        hresp = 2'b01;
      end
      if ((state_q == S_LAST) && !write_q) begin
        hrdata = mem[word_idx];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Bench for ahb_sram_slv: two instances (WAIT_CYC=0 and WAIT_CYC=1) driven
// from a transfer queue; a word-array memory model and per-transfer timing
// expectations derived from the bus rules check every cycle.
module tb_ahb_sram_slv;

  localparam int AW = 10;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s    [2];
  logic        hsel_s   [2];
  logic [31:0] haddr_s  [2];
  logic [1:0]  htrans_s [2];
  logic [2:0]  hsize_s  [2];
  logic        hwrite_s [2];
  logic [2:0]  hburst_s [2];
  logic [3:0]  hprot_s  [2];
  logic [31:0] hwdata_s [2];
  logic [31:0] hrdata_o [2];
  logic        hready_o [2];
  logic [1:0]  hresp_o  [2];

  ahb_sram_slv #(.ADDR_W(AW), .WAIT_CYC(0)) u_dut0 (
    .pll_core_cpuclk(clk),       .pad_cpu_rst(rst_s[0]),
    .hsel(hsel_s[0]),            .haddr(haddr_s[0]),
    .htrans(htrans_s[0]),        .hsize(hsize_s[0]),
    .hwrite(hwrite_s[0]),        .hburst(hburst_s[0]),
    .hprot(hprot_s[0]),          .hwdata(hwdata_s[0]),
    .hrdata(hrdata_o[0]),        .hready(hready_o[0]),
    .hresp(hresp_o[0])
  );

  ahb_sram_slv #(.ADDR_W(AW), .WAIT_CYC(1)) u_dut1 (
    .pll_core_cpuclk(clk),       .pad_cpu_rst(rst_s[1]),
    .hsel(hsel_s[1]),            .haddr(haddr_s[1]),
    .htrans(htrans_s[1]),        .hsize(hsize_s[1]),
    .hwrite(hwrite_s[1]),        .hburst(hburst_s[1]),
    .hprot(hprot_s[1]),          .hwdata(hwdata_s[1]),
    .hrdata(hrdata_o[1]),        .hready(hready_o[1]),
    .hresp(hresp_o[1])
  );

  int          total = 0;
  int          bad   = 0;
  int          wc [2] = '{0, 1};
  logic [31:0] mdl [2][1 << AW];
  xfer_t       q[$];
  logic [31:0] last_rd;
  int          lows_obs [2] = '{0, 0};
  int          errs_obs [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic sel, input logic [1:0] tr, input logic [2:0] sz,
                      input logic wr, input logic [31:0] a, input logic [31:0] wd);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.size = sz; x.wr = wr; x.addr = a; x.wdata = wd;
    q.push_back(x);
  endtask

  task automatic drive(input int d, input xfer_t x);
    hsel_s[d]   = x.sel;
    htrans_s[d] = x.trans;
    hsize_s[d]  = x.size;
    hwrite_s[d] = x.wr;
    haddr_s[d]  = x.addr;
    hburst_s[d] = 3'($urandom);
    hprot_s[d]  = 4'($urandom);
  endtask

  function automatic bit is_err(input xfer_t x);
    return (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
           (x.size == 3'd2 && x.addr[1:0] != 2'b00);
  endfunction

  // Model write: each byte lane b of the addressed word is replaced when it
  // lies inside the transfer's naturally aligned size window.
  task automatic apply_wr(input int d, input xfer_t x);
    int idx;
    int lo;
    int nb;
    idx = int'(x.addr[AW+1:2]);
    nb  = 1 << x.size;
    lo  = (int'(x.addr[1:0]) / nb) * nb;
    for (int b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + nb) mdl[d][idx][8*b +: 8] = x.wdata[8*b +: 8];
    end
  endtask

  // Plays the queue into instance d. At each falling edge the response seen
  // is the one the next rising edge will act on, so an address driven now is
  // accepted at that edge exactly when the sampled hready is high.
  task automatic run(input int d);
    xfer_t       cur, dp, idle_x;
    bit          dp_v, dp_err, fin, have_pend;
    int          dp_cyc, budget;
    logic        rdy;
    logic [1:0]  rsp;
    logic [31:0] rd;
    idle_x = '0; cur = idle_x; dp = idle_x;
    dp_v = 0; dp_err = 0; have_pend = 0; dp_cyc = 0;
    budget = 12 * q.size() + 40;
    while ((q.size() > 0 || dp_v || have_pend) && budget > 0) begin
      @(negedge clk);
      budget--;
      rdy = hready_o[d]; rsp = hresp_o[d]; rd = hrdata_o[d];
      if (!rdy) lows_obs[d]++;
      if (rdy && rsp == 2'b01) errs_obs[d]++;
      if (dp_v) begin
        dp_cyc++;
        fin = dp_err ? (dp_cyc >= 2) : (dp_cyc >= wc[d] + 1);
        hwdata_s[d] = dp.wdata;
        check($sformatf("d%0d_hready_dp", d), 32'(rdy), 32'(fin));
        check($sformatf("d%0d_hresp_dp", d), 32'(rsp), dp_err ? 32'd1 : 32'd0);
        if (dp_err || !fin) begin
          check($sformatf("d%0d_hrdata_zero", d), rd, 32'h0);
        end else if (!dp.wr) begin
          check($sformatf("d%0d_rdata@%h", d, dp.addr), rd, mdl[d][int'(dp.addr[AW+1:2])]);
          last_rd = rd;
        end
        if (fin) begin
          if (!dp_err && dp.wr) apply_wr(d, dp);
          dp_v = 0;
        end
      end else begin
        hwdata_s[d] = $urandom;
        check($sformatf("d%0d_hready_idle", d), 32'(rdy), 32'd1);
        check($sformatf("d%0d_hresp_idle", d), 32'(rsp), 32'd0);
        check($sformatf("d%0d_hrdata_idle", d), rd, 32'h0);
      end
      if (!have_pend) begin
        cur = (q.size() > 0) ? q.pop_front() : idle_x;
        have_pend = 1;
      end
      drive(d, cur);
      if (rdy) begin
        if (cur.sel && cur.trans[1]) begin
          dp = cur; dp_v = 1; dp_cyc = 0; dp_err = is_err(cur);
        end
        have_pend = 0;
      end
    end
    check($sformatf("d%0d_run_drained", d), 32'(q.size()) + 32'(dp_v) + 32'(have_pend), 32'd0);
    q.delete();
  endtask

  task automatic init_words(input int d);
    for (int w = 0; w < 16; w++) push(1, 2'b10, 3'd2, 1, 32'(w * 4), $urandom);
  endtask

  task automatic readback(input int d);
    for (int w = 0; w < 16; w++)
      push(1, 2'b10, 3'd2, 0, ($urandom & 32'hFFFF_F000) | 32'(w * 4), 32'h0);
  endtask

  task automatic push_rand();
    logic [2:0]  sz;
    logic [31:0] a;
    sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
    end
    push($urandom_range(0, 7) != 0, 2'($urandom), sz, 1'($urandom), a, $urandom);
  endtask

  // Reset asserted while a write sits in WAIT must abort it.
  task automatic rst_abort();
    logic [31:0] old;
    xfer_t       x;
    old = mdl[1][12];
    @(negedge clk);
    x.sel = 1; x.trans = 2'b10; x.size = 3'd2; x.wr = 1; x.addr = 32'h30; x.wdata = 32'h0;
    drive(1, x);
    hwdata_s[1] = $urandom;
    @(negedge clk);
    check("d1_rst_wait_hready", 32'(hready_o[1]), 32'd0);
    x = '0;
    drive(1, x);
    hwdata_s[1] = 32'h1234_5678;
    rst_s[1] = 1'b1;
    @(negedge clk);
    check("d1_rst_hready", 32'(hready_o[1]), 32'd1);
    check("d1_rst_hresp", 32'(hresp_o[1]), 32'd0);
    check("d1_rst_hrdata", hrdata_o[1], 32'h0);
    rst_s[1] = 1'b0;
    @(negedge clk);
    check("d1_post_rst_hready", 32'(hready_o[1]), 32'd1);
    push(1, 2'b10, 3'd2, 0, 32'h30, 32'h0);
    run(1);
    check("d1_rst_no_write", last_rd, old);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, e0;
    xfer_t z;
    z = '0;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1;
      drive(d, z);
      hwdata_s[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_reset_hready", d), 32'(hready_o[d]), 32'd1);
      check($sformatf("d%0d_reset_hresp", d), 32'(hresp_o[d]), 32'd0);
      check($sformatf("d%0d_reset_hrdata", d), hrdata_o[d], 32'h0);
      rst_s[d] = 1'b0;
    end

    // One-wait-state instance.
    init_words(1);
    run(1);
    push(1, 2'b10, 3'd2, 1, 32'h10, 32'hDEAD_BEEF);
    push(1, 2'b10, 3'd2, 0, 32'h10, 32'h0);
    run(1);
    check("d1_word_wr_rd", last_rd, 32'hDEAD_BEEF);

    push(1, 2'b10, 3'd2, 1, 32'h10, 32'h1122_3344);
    push(1, 2'b10, 3'd0, 1, 32'h13, {8'hAA, 24'($urandom)});
    push(1, 2'b10, 3'd2, 0, 32'h10, 32'h0);
    run(1);
    check("d1_byte_merge", last_rd, 32'hAA22_3344);
    push(1, 2'b10, 3'd1, 1, 32'h10, {16'($urandom), 16'h5566});
    push(1, 2'b11, 3'd2, 0, 32'h10, 32'h0);
    run(1);
    check("d1_half_merge", last_rd, 32'hAA22_5566);

    push(1, 2'b10, 3'd2, 1, 32'h0, 32'hCAFE_F00D);
    run(1);
    e0 = errs_obs[1];
    push(1, 2'b10, 3'd2, 0, 32'h2, 32'h0);
    push(1, 2'b10, 3'd2, 1, 32'h2, 32'h0BAD_BEEF);
    push(1, 2'b10, 3'd2, 0, 32'h0, 32'h0);
    run(1);
    check("d1_err_count", 32'(errs_obs[1] - e0), 32'd2);
    check("d1_err_no_write", last_rd, 32'hCAFE_F00D);

    rst_abort();

    l0 = lows_obs[1];
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        push(0, 2'($urandom), 3'($urandom_range(0, 2)), 1, $urandom, $urandom);
      else
        push(1, {1'b0, 1'($urandom)}, 3'($urandom_range(0, 2)), 1, $urandom, $urandom);
    end
    run(1);
    check("d1_notransfer_no_wait", 32'(lows_obs[1] - l0), 32'd0);
    readback(1);
    run(1);

    for (int i = 0; i < 400; i++) push_rand();
    run(1);
    readback(1);
    run(1);

    // Zero-wait-state instance.
    init_words(0);
    run(0);
    l0 = lows_obs[0];
    push(1, 2'b10, 3'd2, 1, 32'h20, 32'h600D_F00D);
    push(1, 2'b11, 3'd2, 0, 32'h20, 32'h0);
    run(0);
    check("d0_b2b_rd_after_wr", last_rd, 32'h600D_F00D);
    check("d0_b2b_no_wait", 32'(lows_obs[0] - l0), 32'd0);

    for (int i = 0; i < 300; i++) push_rand();
    run(0);
    readback(0);
    run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
